// File: rtl/uart_rx.sv
// 8N1 UART receiver with an internal per-bit counter and a 2-flop input synchronizer.
// Optional macro UART_RX_MAJORITY_EN selects 2-of-3 majority voting at every sample point.
module uart_rx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       uart_rx_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       framing_error_o,
    output logic       rx_busy_o
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t      state_q;
    logic [1:0]  sync_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [2:0]  bit_idx_q;
    logic [7:0]  sr_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        ferr_q;
    logic        busy_q;
    logic        rx_s;
    logic        sample_bit;

    // Flops reset to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rx_i};
        end
    end

    assign rx_s  = sync_q[1];
    assign cnt_d = cnt_q + 16'd1;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample_bit = majority3(rx_s, hist_q[0], hist_q[1]);
`else
    assign sample_bit = rx_s;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            sr_q      <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= 16'd0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q     <= 16'd0;
                        bit_idx_q <= 3'd0;
                        if (sample_bit) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q     <= 16'd0;
                        sr_q      <= {sample_bit, sr_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop-bit lets an immediately following start bit be seen.
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= 16'd0;
                        if (sample_bit) begin
                            data_q  <= sr_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_o          = data_q;
    assign data_valid_o    = valid_q;
    assign framing_error_o = ferr_q;
    assign rx_busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       uart_rx_i;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       framing_error_o;
    logic       rx_busy_o;

    int checks = 0;
    int fails  = 0;

    int         cyc = 0;
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         busy_cycles = 0;
    int         last_valid_cyc = 0;
    logic       both_seen = 1'b0;
    logic [7:0] rx_log [0:31];
    logic [4:0] rx_n = 5'd0;

    int t0;

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .uart_rx_i      (uart_rx_i),
        .data_o         (data_o),
        .data_valid_o   (data_valid_o),
        .framing_error_o(framing_error_o),
        .rx_busy_o      (rx_busy_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (data_valid_o) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc + 1;
            rx_log[rx_n]   <= data_o;
            rx_n           <= rx_n + 5'd1;
        end
        if (framing_error_o) ferr_cnt <= ferr_cnt + 1;
        if (data_valid_o && framing_error_o) both_seen <= 1'b1;
        if (rx_busy_o) busy_cycles <= busy_cycles + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        uart_rx_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // cpb_x100 is the bit period in hundredths of a clock; glitch_c inverts one cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int cpb_x100,
                              input int glitch_c, input int max_c);
        int   idx;
        logic v;
        t0 = cyc;
        for (int c = 0; c < max_c; c++) begin
            idx = (c * 100) / cpb_x100;
            if (idx >= 10) break;
            if (idx == 0) v = 1'b0;
            else if (idx == 9) v = stop_bit;
            else v = d[idx-1];
            uart_rx_i = (c == glitch_c) ? ~v : v;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int         v0;
        int         f0;
        int         b0;
        int         n0;
        int         lat;
        logic [7:0] exp_glitch;

        reset_i   = 1'b1;
        uart_rx_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", 32'(data_o), 32'h00);
        chk("reset_valid", 32'(data_valid_o), 32'h0);
        chk("reset_ferr", 32'(framing_error_o), 32'h0);
        chk("reset_busy", 32'(rx_busy_o), 32'h0);
        reset_i = 1'b0;
        idle(10);

        // Single byte with latency measurement
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h61, 1'b1, 1600, -1, 1000);
        idle(20);
        lat = last_valid_cyc - t0 - 1;
        chk("single_count", 32'(valid_cnt - v0), 32'd1);
        chk("single_data", 32'(data_o), 32'h61);
        chk("single_ferr", 32'(ferr_cnt - f0), 32'd0);
        chk("single_busy_after", 32'(rx_busy_o), 32'h0);
        chk("single_latency_in_range", 32'((lat >= 152) && (lat <= 156)), 32'h1);

        // Back-to-back frames with no idle gap
        v0 = valid_cnt; n0 = int'(rx_n);
        send_frame(8'h00, 1'b1, 1600, -1, 1000);
        send_frame(8'hFF, 1'b1, 1600, -1, 1000);
        send_frame(8'hA5, 1'b1, 1600, -1, 1000);
        idle(20);
        chk("b2b_count", 32'(valid_cnt - v0), 32'd3);
        chk("b2b_byte0", 32'(rx_log[5'(n0)]), 32'h00);
        chk("b2b_byte1", 32'(rx_log[5'(n0 + 1)]), 32'hFF);
        chk("b2b_byte2", 32'(rx_log[5'(n0 + 2)]), 32'hA5);

        // Four-cycle low glitch while idle
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cycles;
        uart_rx_i = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        idle(30);
        chk("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
        chk("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        chk("glitch_busy_short", 32'((busy_cycles - b0) <= 10), 32'h1);
        chk("glitch_busy_low", 32'(rx_busy_o), 32'h0);

        // Bad stop bit, line held low, then a good byte
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1600, -1, 1000);
        uart_rx_i = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        chk("ferr_busy_while_low", 32'(rx_busy_o), 32'h1);
        idle(20);
        chk("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
        chk("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
        chk("ferr_data_held", 32'(data_o), 32'hA5);
        send_frame(8'h12, 1'b1, 1600, -1, 1000);
        idle(20);
        chk("after_ferr_count", 32'(valid_cnt - v0), 32'd1);
        chk("after_ferr_data", 32'(data_o), 32'h12);

        // Baud offset +/-3%
        send_frame(8'hC3, 1'b1, 1552, -1, 1000);
        idle(20);
        chk("baud_fast", 32'(data_o), 32'hC3);
        send_frame(8'h3C, 1'b1, 1648, -1, 1000);
        idle(20);
        chk("baud_slow", 32'(data_o), 32'h3C);

        // Inversion at the sample point of data bit 2
`ifdef UART_RX_MAJORITY_EN
        exp_glitch = 8'h55;
`else
        exp_glitch = 8'h51;
`endif
        send_frame(8'h55, 1'b1, 1600, 56, 1000);
        idle(20);
        chk("sample_glitch", 32'(data_o), 32'(exp_glitch));

        // Asynchronous reset during data bit 4
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h5A, 1'b1, 1600, -1, 88);
        chk("midframe_busy", 32'(rx_busy_o), 32'h1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("rst_async_data", 32'(data_o), 32'h00);
        chk("rst_async_valid", 32'(data_valid_o), 32'h0);
        chk("rst_async_ferr", 32'(framing_error_o), 32'h0);
        chk("rst_async_busy", 32'(rx_busy_o), 32'h0);
        uart_rx_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk);
        #1;
        idle(200);
        chk("rst_no_valid", 32'(valid_cnt - v0), 32'd0);
        chk("rst_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        chk("rst_idle_busy", 32'(rx_busy_o), 32'h0);

        chk("pulse_exclusive", 32'(both_seen), 32'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receives 8N1 asynchronous serial frames on a single input pin and presents each good byte as an 8-bit word with a one-cycle valid strobe. It is the receive-side counterpart to the design's UART transmitter and uses the same `clk_i`/`reset_i` domain and the same `data_valid`/`data` naming. The bit timing comes from an internal per-bit counter, so no external baud tick is needed. The block is the entry point for host-to-FPGA command bytes on the camera test board.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 217: `clk_i` cycles per bit period, e.g. 25 MHz / 115200. Legal range 8 to 65535.

Ports:
- `clk_i`  input  1  system clock
- `reset_i`  input  1  reset, asynchronous, active-high
- `uart_rx_i`  input  1  serial line, idle high; asynchronous to `clk_i`
- `data_o`  output  8  last good received byte; holds its value until the next good frame
- `data_valid_o`  output  1  one-cycle pulse; `data_o` is new in the same cycle
- `framing_error_o`  output  1  one-cycle pulse when a frame has a bad stop bit
- `rx_busy_o`  output  1  high while a frame is in progress (any state except IDLE)

## Operation
- **Synchronizer:** `uart_rx_i` passes through a 2-flop synchronizer whose flops reset to 1. All logic below uses the synchronized value `rx_s`.
- **Constants:**
  - HALF = CLKS_PER_BIT/2, integer division.
  - The bit counter is 16 bits wide.
- **State machine:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE:** when `rx_s`==0, go to START and clear the counter.
- **START:**
  - Counts HALF cycles. The sample point is the cycle where the counter equals HALF-1.
  - Sampled 1 (false start or glitch): go to IDLE with no output.
  - Sampled 0: go to DATA, clear the counter and bit index.
- **DATA:**
  - The sample point is counter == CLKS_PER_BIT-1, after which the counter wraps to 0.
  - Each sampled bit shifts into the shift register, LSB first: `sr <= {bit, sr[7:1]}`.
  - After bit index 7, go to STOP.
- **STOP:** sample at counter == CLKS_PER_BIT-1.
  - Sampled 1: `data_o <= sr`, pulse `data_valid_o`, go to IDLE.
  - Sampled 0: pulse `framing_error_o`, leave `data_o` unchanged, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s`==1, then go to IDLE. This stops a break condition from retriggering frames.
- **Back-to-back frames:** returning to IDLE at the middle of the stop bit lets a start bit that immediately follows the stop bit be caught.
- **Pulse exclusivity:** `data_valid_o` and `framing_error_o` are never high in the same cycle.
- **No backpressure:** the consumer must take `data_o` on the `data_valid_o` cycle or read it later from the held register.

## Timing
- **Reset values:**
  - `data_o`=8'h00, `data_valid_o`=0, `framing_error_o`=0, `rx_busy_o`=0.
  - State IDLE; synchronizer flops at 1.
- **Reset mid-frame:** aborts the frame immediately. No `data_valid_o` or `framing_error_o` pulse is produced for the aborted frame.
- **Latency:** from the first `clk_i` edge at which `uart_rx_i` is low, `data_valid_o` rises nominally 2 + HALF + 9*CLKS_PER_BIT cycles later. Bench tolerance is ±2 cycles.
- **Outputs:** all outputs are registered. `data_o` and `data_valid_o` change on the same edge.
- **`rx_busy_o`:**
  - Rises one cycle after `rx_s` falls in IDLE.
  - Falls on the cycle the machine re-enters IDLE.
- **Baud tolerance:** frames sent up to ±3% off nominal baud must decode correctly.

## Configuration
- **Macro:** `UART_RX_MAJORITY_EN`.
- **Defined:** every sample point, in START, DATA and STOP, uses the 2-of-3 majority of `rx_s` at the sample cycle and the two preceding cycles. Decision timing is unchanged.
- **Undefined:** every sample point uses the single value `rx_s` at the sample cycle. No majority logic is synthesized.

## Test plan
All scenarios use CLKS_PER_BIT=16 (HALF=8).
- **Single byte:** line driven with 0x61 in 8N1 at 16 cycles/bit → exactly one `data_valid_o` pulse with `data_o`=0x61, `framing_error_o` stays 0, `rx_busy_o` low afterward.
- **Back-to-back bytes:** 0x00, 0xFF, 0xA5 sent with no idle gap, and a loopback from the team's UART transmitter with a baud tick every 16 clocks → three pulses with values 0x00, 0xFF, 0xA5 in order.
- **Short glitch:** low glitch of 4 cycles in idle → no pulses, `rx_busy_o` high for at most ~10 cycles, then back to IDLE.
- **Framing error:** frame 0x3C with stop bit 0, line held low 40 further cycles, then released high, then a good 0x12 → one `framing_error_o` pulse, no valid pulse for the bad frame, `data_o` still shows the prior value, then 0x12 received.
- **Reset mid-frame:** `reset_i` asserted during bit 4 of a frame → outputs go to reset values at once with no `clk_i` edge needed, and the partial frame produces no pulse.
- **Sample-point glitch:** 1-cycle inversion at the sample point of bit 2 of 0x55 → with `UART_RX_MAJORITY_EN` defined, `data_o`=0x55; without it, `data_o`=0x51.
